// File: rtl/sum_cu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sum_cu_pkg                                             |
// | Description : State encoding, mux-select constants and counter       |
// |               sizing helper shared by the sum_cu control unit.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package sum_cu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    CMP  = 3'd2,
    ADD  = 3'd3,
    INC  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic SEL_ZERO = 1'b0;
  localparam logic SEL_NEXT = 1'b1;

  // Hold counter runs 0..hold-1; keep at least one bit for hold == 1.
  function automatic int hold_cnt_width(input int hold);
    return (hold < 2) ? 1 : $clog2(hold);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_cu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sum_cu_if                                              |
// | Description : Control/status bundle between sum_cu and its datapath. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface sum_cu_if;

  logic start;
  logic stepTick;
  logic iLeLimit;
  logic iSrcMuxSel;
  logic sumSrcMuxSel;
  logic iEn;
  logic sumEn;
  logic outLoad;
  logic busy;
  logic done;

  modport master (
    input  start, stepTick, iLeLimit,
    output iSrcMuxSel, sumSrcMuxSel, iEn, sumEn, outLoad, busy, done
  );

  modport slave (
    output start, stepTick, iLeLimit,
    input  iSrcMuxSel, sumSrcMuxSel, iEn, sumEn, outLoad, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/sum_cu_hold_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sum_cu_hold_cnt                                        |
// | Description : Clearable up-counter that stops at TC_VALUE and flags  |
// |               terminal count; times the DONE hold of sum_cu.         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module sum_cu_hold_cnt #(
  parameter int               WIDTH    = 2,
  parameter logic [WIDTH-1:0] TC_VALUE = '0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/sum_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sum_cu                                                 |
// | Description : Moore control unit sequencing the 0..limit summation   |
// |               datapath. Define SUM_CU_AUTO_RESTART_EN to loop from   |
// |               DONE straight back to INIT without a start pulse.      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module sum_cu
  import sum_cu_pkg::*;
#(
  parameter int DONE_HOLD = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  sum_cu_if.master  bus
);

  localparam int               c_CNT_W   = hold_cnt_width(DONE_HOLD);
  localparam logic [c_CNT_W-1:0] c_HOLD_TC = c_CNT_W'(DONE_HOLD - 1);

  state_t r_state;
  logic   w_hold_tc;

  sum_cu_hold_cnt #(
    .WIDTH    (c_CNT_W),
    .TC_VALUE (c_HOLD_TC)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_clr (r_state != DONE),
    .i_en  (r_state == DONE),
    .o_tc  (w_hold_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (bus.start)    r_state <= INIT;
        INIT: if (bus.stepTick) r_state <= CMP;
        CMP:  if (bus.stepTick) r_state <= bus.iLeLimit ? ADD : DONE;
        ADD:  if (bus.stepTick) r_state <= INC;
        INC:  if (bus.stepTick) r_state <= CMP;
        DONE: begin
          if (w_hold_tc) begin
`ifdef SUM_CU_AUTO_RESTART_EN
            r_state <= INIT;
`else
            r_state <= IDLE;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Enables are gated by stepTick so a stalled state never touches the datapath.
  always_comb begin
    bus.iSrcMuxSel   = SEL_ZERO;
    bus.sumSrcMuxSel = SEL_ZERO;
    bus.iEn          = 1'b0;
    bus.sumEn        = 1'b0;
    bus.outLoad      = 1'b0;
    bus.busy         = (r_state != IDLE);
    bus.done         = (r_state == DONE);
    case (r_state)
      INIT: begin
        bus.iEn   = bus.stepTick;
        bus.sumEn = bus.stepTick;
      end
      ADD: begin
        bus.sumSrcMuxSel = SEL_NEXT;
        bus.sumEn        = bus.stepTick;
      end
      INC: begin
        bus.iSrcMuxSel = SEL_NEXT;
        bus.iEn        = bus.stepTick;
        bus.outLoad    = bus.stepTick;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sum_cu                                              |
// | Description : Scoreboard bench for sum_cu with a 0..10 sum datapath. |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_sum_cu;

  localparam int LIMIT = 10;
  localparam int HOLD  = 4;

  typedef struct {
    int lat;
    int ien;
    int suen;
    int outl;
    int sum;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic force_fail = 1'b0;
  logic paced = 1'b0;
  int   cyc = 0;
  int unsigned i_reg = 0;
  int unsigned sum_reg = 0;

  always #5 clk = ~clk;

  sum_cu_if bus ();

  sum_cu #(.DONE_HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Datapath model: i and sum registers driven by the control outputs.
  assign bus.iLeLimit = !force_fail && (i_reg <= LIMIT);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.iEn)   i_reg   <= bus.iSrcMuxSel ? i_reg + 1 : 0;
    if (bus.sumEn) sum_reg <= bus.sumSrcMuxSel ? sum_reg + i_reg : 0;
  end

  initial begin
    bus.stepTick = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.stepTick = paced ? (cyc % 4 == 0) : 1'b1;
    end
  end

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  int   done_seen = 0;
  int   busy_drops = 0;
  int   n_ien = 0, n_sumen = 0, n_outl = 0, done_len = 0;
  logic viol = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int outs();
    return int'({bus.busy, bus.done, bus.iEn, bus.sumEn, bus.outLoad,
                 bus.iSrcMuxSel, bus.sumSrcMuxSel});
  endfunction

  // Monitor: counts pulses per run and scores each run when done rises.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if ((bus.busy && !prev_busy) || (!bus.done && prev_done)) begin
        n_ien = 0; n_sumen = 0; n_outl = 0; viol = 1'b0;
      end
      if (prev_busy && !bus.busy) busy_drops++;
      if (!bus.done && prev_done) begin
        done_seen++;
        check("done_len", done_len, HOLD);
`ifdef SUM_CU_AUTO_RESTART_EN
        check("restart_in_init", outs(), 7'b1011000);
`else
        check("idle_after_done", int'(bus.busy), 0);
`endif
      end
      if (bus.done && !prev_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          if (e.lat > 0) check("done_latency", cyc - start_cyc, e.lat);
          check("iEn_pulses", n_ien, e.ien);
          check("sumEn_pulses", n_sumen, e.suen);
          check("outLoad_pulses", n_outl, e.outl);
          check("final_sum", int'(sum_reg), e.sum);
          check("enable_without_tick", int'(viol), 0);
        end
        done_len = 0;
      end
      if (bus.done)    done_len++;
      if (bus.iEn)     n_ien++;
      if (bus.sumEn)   n_sumen++;
      if (bus.outLoad) n_outl++;
      if (!bus.stepTick && (bus.iEn || bus.sumEn || bus.outLoad)) viol = 1'b1;
      prev_busy = bus.busy;
      prev_done = bus.done;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_runs(input int target, input int budget);
    int k = 0;
    while (done_seen < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("run_complete", int'(done_seen >= target), 1);
  endtask

  // Waits (bounded) at negedges for a one-hot state signature on the outputs.
  task automatic wait_sig(input string name, input int mask);
    int k = 0;
    @(negedge clk);
    while ((outs() & mask) == 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(name, int'((outs() & mask) != 0), 1);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs(), 0);

`ifndef SUM_CU_AUTO_RESTART_EN
    // full-speed run
    sb.push_back('{36, 12, 12, 11, 55});
    pulse_start();
    wait_runs(1, 200);

    // paced run, one tick in four
    paced = 1'b1;
    sb.push_back('{0, 12, 12, 11, 55});
    pulse_start();
    wait_runs(2, 800);
    paced = 1'b0;

    // start pulse while in ADD is ignored
    sb.push_back('{36, 12, 12, 11, 55});
    pulse_start();
    wait_sig("reach_add", 7'b0000001);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_runs(3, 200);
    repeat (3) @(negedge clk);
    check("idle_after_busy_start", outs(), 0);

    // reset asserted in INC
    pulse_start();
    wait_sig("reach_inc", 7'b0000010);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_in_inc", outs(), 0);
    reset = 1'b0;
    sb.push_back('{36, 12, 12, 11, 55});
    pulse_start();
    wait_runs(4, 200);

    // limit fails at the first compare
    force_fail = 1'b1;
    sb.push_back('{3, 1, 1, 0, 0});
    pulse_start();
    wait_runs(5, 100);
    force_fail = 1'b0;
`else
    // auto-restart: two back-to-back runs from a single start
    sb.push_back('{36, 12, 12, 11, 55});
    sb.push_back('{0, 12, 12, 11, 55});
    pulse_start();
    wait_runs(1, 200);
    wait_runs(2, 200);
    check("busy_drops", busy_drops, 0);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_cu.md
SUM_CU -- requirements
Module: sum_cu

Interface
REQ-001 SHALL have parameter DONE_HOLD, default 4: number of cycles `done` stays high before returning to IDLE.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request one accumulation run; sampled only in IDLE.
REQ-005 SHALL have port stepTick, input, 1 bit: step enable that paces the sequence; tie high for full speed.
REQ-006 SHALL have port iLeLimit, input, 1 bit: datapath status, high when counter i <= limit.
REQ-007 SHALL have port iSrcMuxSel, output, 1 bit: i source, 0 = constant 0, 1 = i+1.
REQ-008 SHALL have port sumSrcMuxSel, output, 1 bit: sum source, 0 = constant 0, 1 = sum+i.
REQ-009 SHALL have port iEn, output, 1 bit: i register load enable.
REQ-010 SHALL have port sumEn, output, 1 bit: sum register load enable.
REQ-011 SHALL have port outLoad, output, 1 bit: output buffer load (feeds the FND display value).
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: high in DONE.

Function
REQ-014 SHALL be a Moore FSM with states IDLE, INIT, CMP, ADD, INC, DONE; outputs decode from the state register only.
REQ-015 IDLE SHALL go to INIT on the next edge when start=1, regardless of stepTick, with all enables 0.
REQ-016 INIT SHALL drive iSrcMuxSel=0, sumSrcMuxSel=0, iEn=sumEn=stepTick, and go to CMP on stepTick.
REQ-017 CMP SHALL assert no enables; on stepTick it goes to ADD if iLeLimit=1, otherwise to DONE.
REQ-018 ADD SHALL drive sumSrcMuxSel=1, sumEn=stepTick, and go to INC on stepTick.
REQ-019 INC SHALL drive iSrcMuxSel=1, iEn=stepTick, outLoad=stepTick, and go to CMP on stepTick.
REQ-020 In INIT, CMP, ADD and INC, with stepTick=0, SHALL hold state and assert no enable, so there is exactly one datapath update per tick.
REQ-021 DONE SHALL assert done=1 and outLoad=0, count DONE_HOLD cycles (stepTick-independent), then go to IDLE.
REQ-022 start asserted while busy SHALL be ignored and not queued.
REQ-023 Mux selects not named for a state SHALL be driven 0.
REQ-024 DONE_HOLD=1 SHALL give a one-cycle done pulse; DONE_HOLD < 1 is illegal.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE and clear the hold counter; it takes priority over start and over every state.
REQ-026 After reset all outputs SHALL be 0, including reset asserted mid-run.

Configuration
REQ-027 With macro SUM_CU_AUTO_RESTART_EN defined, DONE SHALL go directly to INIT after DONE_HOLD cycles, repeating runs without start.
REQ-028 Without SUM_CU_AUTO_RESTART_EN, DONE SHALL go to IDLE and wait for start.

Structure
REQ-029 Package sum_cu_pkg SHALL hold the state enum (3-bit encoding) and the mux-select constants (SEL_ZERO=0, SEL_NEXT=1).
REQ-030 The DONE hold counter SHALL be sub-module sum_cu_hold_cnt: clear, enable, parameter-width terminal-count flag.
REQ-031 The datapath SHALL stay outside this block; sum_cu connects only through the ports above.

Verification
REQ-032 Scenario "full-speed run": with stepTick=1, a datapath model (i init 0, limit 10) and a start pulse, done SHALL rise 36 cycles after the start edge, with iEn and sumEn each pulsing 12 times, outLoad pulsing 11 times and final sum 55.
REQ-033 Scenario "paced run": with stepTick high 1 cycle in 4, the same run SHALL produce identical enable counts and sum 55, with no enable asserted while stepTick=0.
REQ-034 Scenario "busy start": a start pulse in ADD SHALL leave state and enable sequence unchanged, and after DONE_HOLD=4 done cycles the block SHALL sit in IDLE.
REQ-035 Scenario "mid-run reset": reset asserted in INC SHALL give IDLE with all outputs 0 on the next edge; a following start SHALL complete normally with sum 55.
REQ-036 Scenario "limit fails immediately": with iLeLimit tied 0, the sequence SHALL be INIT, CMP, DONE, with done high 3 cycles after the start edge and outLoad never asserted.
REQ-037 Scenario "auto-restart" (SUM_CU_AUTO_RESTART_EN defined): after 4 done cycles the block SHALL enter INIT with no start pulse, and busy SHALL never drop.
